// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with registered result/flags and a valid/ready handshake on both sides.
// Optional unsigned shift-add multiplier (opcode 1000) is built only when ALU_SEQ_MUL_EN is defined.
module alu_seq #(
  parameter int WIDTH           = 32,
  parameter int MUL_CYCLES_LOG2 = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow,
  output logic             err
);

  if (WIDTH < 4 || WIDTH > 64 || (2 ** MUL_CYCLES_LOG2) < WIDTH) begin : g_param_chk
    $error("alu_seq: illegal WIDTH / MUL_CYCLES_LOG2 combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             c;
    logic             v;
    logic             e;
  } alu_out_t;

  state_t   state, state_n;
  logic     accept, is_mul, load_alu, mul_done;
  alu_out_t alu_p0;

  // Single-cycle operations; SLT takes the true signed ordering as sign ^ overflow of a - b.
  function automatic alu_out_t alu_eval(input logic [3:0] op,
                                        input logic signed [WIDTH-1:0] x,
                                        input logic signed [WIDTH-1:0] y);
    alu_out_t       o;
    logic [WIDTH:0] add_s, sub_s;
    logic           add_v, sub_v;
    add_s = {1'b0, x} + {1'b0, y};
    sub_s = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, 1'b1};
    add_v = (x[WIDTH-1] == y[WIDTH-1]) && (add_s[WIDTH-1] != x[WIDTH-1]);
    sub_v = (x[WIDTH-1] != y[WIDTH-1]) && (sub_s[WIDTH-1] != x[WIDTH-1]);
    o = '0;
    case (op)
      4'b0000: o.res = x & y;
      4'b0001: o.res = x | y;
      4'b0010: begin o.res = add_s[WIDTH-1:0]; o.c = add_s[WIDTH]; o.v = add_v; end
      4'b0110: begin o.res = sub_s[WIDTH-1:0]; o.c = sub_s[WIDTH]; o.v = sub_v; end
      4'b0111: begin
        o.res = {{(WIDTH-1){1'b0}}, sub_s[WIDTH-1] ^ sub_v};
        o.c   = sub_s[WIDTH];
      end
      4'b1100: o.res = ~x & ~y;
      default: o.e = 1'b1;
    endcase
    return o;
  endfunction

  assign alu_p0   = alu_eval(opcode, a, b);
  assign in_ready = !rst && ((state == S_IDLE) || (state == S_HOLD && out_ready));
  assign accept   = in_valid && in_ready;
  assign load_alu = accept && !is_mul;

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0]       acc_p1, mcand_p1, acc_nxt;
  logic [WIDTH-1:0]         mplier_p1;
  logic [MUL_CYCLES_LOG2-1:0] cnt;

  assign is_mul   = (opcode == 4'b1000);
  assign mul_done = (state == S_MUL) && (cnt == MUL_CYCLES_LOG2'(WIDTH - 1));
  assign acc_nxt  = mplier_p1[0] ? acc_p1 + mcand_p1 : acc_p1;

  // Multiplier stage: operands latched on accept, one multiplier bit consumed per cycle.
  always_ff @(posedge clk) begin
    if (accept && is_mul) begin
      acc_p1    <= '0;
      mcand_p1  <= {{WIDTH{1'b0}}, a};
      mplier_p1 <= b;
    end else if (state == S_MUL) begin
      acc_p1    <= acc_nxt;
      mcand_p1  <= mcand_p1 << 1;
      mplier_p1 <= mplier_p1 >> 1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   cnt <= '0;
    else if (accept && is_mul) cnt <= '0;
    else if (state == S_MUL)   cnt <= cnt + MUL_CYCLES_LOG2'(1);
  end
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (accept) state_n = is_mul ? S_MUL : S_HOLD;
      S_MUL:  if (mul_done) state_n = S_HOLD;
      S_HOLD: if (out_ready) state_n = accept ? (is_mul ? S_MUL : S_HOLD) : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Output stage: result is valid exactly while the FSM sits in HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= (state_n == S_HOLD);
      if (load_alu) begin
        result    <= alu_p0.res;
        zero      <= ~|alu_p0.res;
        carry_out <= alu_p0.c;
        overflow  <= alu_p0.v;
        err       <= alu_p0.e;
      end
`ifdef ALU_SEQ_MUL_EN
      else if (mul_done) begin
        result    <= acc_nxt[WIDTH-1:0];
        zero      <= ~|acc_nxt[WIDTH-1:0];
        carry_out <= 1'b0;
        overflow  <= |acc_nxt[2*WIDTH-1:WIDTH];
        err       <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH = 8; expectations follow ALU_SEQ_MUL_EN.
module tb_alu_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic         zero, carry_out, overflow, err;
  logic [W-1:0] a, b, result;
  logic [3:0]   opcode;
  int           errors = 0;
  int           checks = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W), .MUL_CYCLES_LOG2(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carry_out(carry_out), .overflow(overflow), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid = 1'b1;
    opcode   = op;
    a        = x;
    b        = y;
  endtask

  task automatic chk8(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [W-1:0] r,
                         input logic z, input logic c, input logic v, input logic e);
    chk1({tag, ".out_valid"}, out_valid, 1'b1);
    chk8({tag, ".result"}, result, r);
    chk1({tag, ".zero"}, zero, z);
    chk1({tag, ".carry"}, carry_out, c);
    chk1({tag, ".ovf"}, overflow, v);
    chk1({tag, ".err"}, err, e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, ".out_valid"}, out_valid, 1'b0);
    chk8({tag, ".result"}, result, 8'h00);
    chk1({tag, ".zero"}, zero, 1'b0);
    chk1({tag, ".carry"}, carry_out, 1'b0);
    chk1({tag, ".ovf"}, overflow, 1'b0);
    chk1({tag, ".err"}, err, 1'b0);
    chk1({tag, ".in_ready"}, in_ready, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; opcode = 4'b0000;
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;
    #1;
    chk1("post_reset.in_ready", in_ready, 1'b1);

    // Back-to-back single-cycle ops, one per cycle.
    issue(4'b0010, 8'h7F, 8'h01);
    tick(); chk_out("add_ovf", 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
    issue(4'b0110, 8'h05, 8'h05);
    tick(); chk_out("sub_eq", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    issue(4'b0111, 8'hFE, 8'h01);
    tick(); chk_out("slt_neg", 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(4'b0101, 8'h12, 8'h34);
    tick(); chk_out("illegal", 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(4'b1100, 8'hF0, 8'h0C);
    tick(); chk_out("nor", 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(4'b0010, 8'h80, 8'hFF);
    tick(); chk_out("add_negneg", 8'h7F, 1'b0, 1'b1, 1'b1, 1'b0);
    issue(4'b0110, 8'h80, 8'h01);
    tick(); chk_out("sub_ovf", 8'h7F, 1'b0, 1'b1, 1'b1, 1'b0);
    issue(4'b0111, 8'h80, 8'h01);
    tick(); chk_out("slt_ovf", 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(4'b0111, 8'h01, 8'hFE);
    tick(); chk_out("slt_false", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(4'b0010, 8'hFF, 8'h01);
    tick(); chk_out("add_wrap", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    tick(); chk1("drain.out_valid", out_valid, 1'b0);

    // Backpressure: result must hold while a pending op waits.
    out_ready = 1'b0;
    issue(4'b0000, 8'hF0, 8'h3C);
    tick();
    issue(4'b0001, 8'h0F, 8'hA0);
    for (int i = 0; i < 5; i++) begin
      chk_out("hold_and", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
      chk1("hold.in_ready", in_ready, 1'b0);
      tick();
    end
    chk8("hold_end.result", result, 8'h30);
    out_ready = 1'b1;
    #1;
    chk1("release.in_ready", in_ready, 1'b1);
    tick(); chk_out("or_after_hold", 8'hAF, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    tick(); chk1("drain2.out_valid", out_valid, 1'b0);

    // Multiply; a competing op is presented throughout and must be ignored.
    issue(4'b1000, 8'h10, 8'h11);
    tick();
`ifdef ALU_SEQ_MUL_EN
    issue(4'b0010, 8'h01, 8'h01);
    chk1("mul.in_ready", in_ready, 1'b0);
    chk1("mul.out_valid", out_valid, 1'b0);
    for (int k = 1; k < W; k++) begin
      tick();
      chk1("mul_busy.in_ready", in_ready, 1'b0);
      chk1("mul_busy.out_valid", out_valid, 1'b0);
    end
    tick(); chk_out("mul", 8'h10, 1'b0, 1'b0, 1'b1, 1'b0);
`else
    chk_out("mul_disabled", 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
`endif
    in_valid = 1'b0;
    tick(); chk1("mul_drain.out_valid", out_valid, 1'b0);

    // Reset on the third cycle of a multiply (or while holding, without the multiplier).
    out_ready = 1'b0;
    issue(4'b1000, 8'hFF, 8'hFF);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    chk_all_zero("abort");
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk1("abort_release.in_ready", in_ready, 1'b1);
    for (int i = 0; i < W + 2; i++) begin
      tick();
      chk1("abort_discard.out_valid", out_valid, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
